// File: rtl/sodor_imem_rand_responder_if.sv
// Fetch request/response channel between the Sodor core and the instruction-memory responder.
interface sodor_imem_rand_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [31:0] resp_addr;
    logic        kill;
    logic        seed_load;
    logic [31:0] seed;

    modport master (
        output req_valid, req_addr, resp_ready, kill, seed_load, seed,
        input  req_ready, resp_valid, resp_data, resp_addr
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, kill, seed_load, seed,
        output req_ready, resp_valid, resp_data, resp_addr
    );
endinterface

// File: rtl/sodor_imem_rand_responder.sv
// Instruction-memory responder returning LFSR-driven RV32I OP-IMM words with fixed latency.
// Optional macro IMEM_RESP_LOAD_EN additionally emits LB/LBU loads when L[1:0]==0.
module sodor_imem_rand_responder #(
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned WARMUP    = 2,
    parameter logic [31:0] LFSR_SEED = 32'h000001B4
) (
    input logic                       clk,
    input logic                       reset_n,
    sodor_imem_rand_responder_if.slave bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = $clog2(WARMUP + 2);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [2:0]    LAT_C   = 3'(LATENCY);
    localparam logic [31:0]   NOP     = 32'h00000013;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        logic [31:0] n;
        n = l >> 1;
        if (l[0]) n = n ^ 32'h80200003;
        return n;
    endfunction

    // f carries L[31:7]: imm f[24:13], rs1 f[12:8], funct3 f[7:5], rd f[4:0]
    function automatic logic [31:0] gen_instr(input logic [24:0] f, input logic ld);
        logic [11:0] imm;
        logic [2:0]  f3;
        logic [31:0] w;
        imm = f[24:13];
        f3  = f[7:5];
        if (f3 == 3'd1)
            imm = imm & 12'h01F;
        else if (f3 == 3'd5)
            imm = imm & 12'h41F;
        w = {imm, f[12:8], f3, f[4:0], 7'b0010011};
        if (ld)
            w = {f[24:13] & 12'h03C, 5'd0, f3 & 3'b100, f[4:0], 7'b0000011};
        return w;
    endfunction

    logic          active;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   lfsr;
    logic [WW-1:0] warm_cnt;
    logic [2:0]    age_q   [DEPTH];
    logic [31:0]   addr_q  [DEPTH];
    logic [31:0]   instr_q [DEPTH];

    logic        push;
    logic        pop;
    logic        warming;
    logic        is_load;
    logic [31:0] new_instr;

`ifdef IMEM_RESP_LOAD_EN
    assign is_load = (lfsr[1:0] == 2'b00);
`else
    assign is_load = 1'b0;
`endif

    assign warming   = (warm_cnt < WW'(WARMUP));
    assign new_instr = warming ? NOP : gen_instr(lfsr[31:7], is_load);

    assign bus.req_ready  = active && (count < DEPTH_C) && !bus.kill;
    assign push           = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = (count != '0) && (({1'b0, age_q[rd_ptr]} + 4'd1) >= 4'(LATENCY));
    assign pop            = bus.resp_valid && bus.resp_ready;
    assign bus.resp_data  = bus.resp_valid ? instr_q[rd_ptr] : '0;
    assign bus.resp_addr  = bus.resp_valid ? addr_q[rd_ptr]  : '0;

    // Control state: occupancy, pointers, ages, generator
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            lfsr     <= LFSR_SEED;
            warm_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else begin
            active <= 1'b1;
            for (int i = 0; i < DEPTH; i++)
                if (age_q[i] < LAT_C) age_q[i] <= age_q[i] + 3'd1;
            if (bus.kill) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr        <= wr_ptr + PW'(1);
                    age_q[wr_ptr] <= '0;
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
            if (push && warming) warm_cnt <= warm_cnt + WW'(1);
            // A seed load wins over the advance caused by an accept in the same cycle
            if (bus.seed_load)
                lfsr <= (bus.seed == 32'd0) ? LFSR_SEED : bus.seed;
            else if (push && !warming)
                lfsr <= lfsr_step(lfsr);
        end
    end

    // Payload storage
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr]  <= bus.req_addr;
            instr_q[wr_ptr] <= new_instr;
        end
    end
endmodule

// File: tb/tb_sodor_imem_rand_responder.sv
// Directed bench for sodor_imem_rand_responder with a queue-based reference model.
module tb_sodor_imem_rand_responder;
    localparam int unsigned LATENCY   = 1;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned WARMUP    = 2;
    localparam logic [31:0] LFSR_SEED = 32'h000001B4;

    logic clk;
    logic reset_n;
    sodor_imem_rand_responder_if bus ();

    sodor_imem_rand_responder #(
        .LATENCY(LATENCY), .DEPTH(DEPTH), .WARMUP(WARMUP), .LFSR_SEED(LFSR_SEED)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: instruction stream derived from the field rules
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          t;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_lfsr;
    int          m_warm;
    bit          m_active;
    int          cyc;

    function automatic logic [31:0] model_instr(input logic [31:0] l);
        logic [31:0] imm, rs1, f3, rd;
        imm = (l >> 20) & 32'hFFF;
        rs1 = (l >> 15) & 32'h1F;
        f3  = (l >> 12) & 32'h7;
        rd  = (l >> 7)  & 32'h1F;
`ifdef IMEM_RESP_LOAD_EN
        if ((l & 32'h3) == 0)
            return ((imm & 32'h03C) << 20) | ((f3 & 32'h4) << 12) | (rd << 7) | 32'h03;
`endif
        if (f3 == 1) imm = imm & 32'h01F;
        if (f3 == 5) imm = imm & 32'h41F;
        return (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] l);
        return (l >> 1) ^ ((l % 2 == 1) ? 32'h80200003 : 32'h0);
    endfunction

    always @(negedge clk) begin
        bit   exp_ready, exp_valid;
        ent_t e;
        if (!reset_n) begin
            mq.delete();
            m_lfsr   = LFSR_SEED;
            m_warm   = 0;
            m_active = 0;
            check("rst_req_ready", bus.req_ready, 0);
            check("rst_resp_valid", bus.resp_valid, 0);
            check("rst_resp_data", bus.resp_data, 0);
            check("rst_resp_addr", bus.resp_addr, 0);
        end else begin
            exp_ready = m_active && (mq.size() < DEPTH) && !bus.kill;
            exp_valid = (mq.size() > 0) && (cyc >= mq[0].t + int'(LATENCY));
            check("req_ready", bus.req_ready, exp_ready);
            check("resp_valid", bus.resp_valid, exp_valid);
            if (exp_valid) begin
                check("resp_data", bus.resp_data, mq[0].data);
                check("resp_addr", bus.resp_addr, mq[0].addr);
            end
            if (bus.kill) mq.delete();
            else begin
                if (exp_valid && bus.resp_ready) void'(mq.pop_front());
                if (exp_ready && bus.req_valid) begin
                    e.addr = bus.req_addr;
                    e.t    = cyc;
                    if (m_warm < WARMUP) begin
                        e.data = 32'h13;
                        m_warm++;
                    end else begin
                        e.data = model_instr(m_lfsr);
                        if (!bus.seed_load) m_lfsr = model_next(m_lfsr);
                    end
                    mq.push_back(e);
                end
            end
            if (bus.seed_load) m_lfsr = (bus.seed == 0) ? LFSR_SEED : bus.seed;
            m_active = 1;
        end
        cyc++;
    end

    // Handshake recorder used by the directed literal checks
    logic [31:0] got_data[$];
    logic [31:0] got_addr[$];

    always @(negedge clk) begin
        if (reset_n && bus.resp_valid && bus.resp_ready) begin
            got_data.push_back(bus.resp_data);
            got_addr.push_back(bus.resp_addr);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_got(input int n, input int budget);
        for (int i = 0; i < budget && got_data.size() < n; i++) next();
        check("resp_count", got_data.size(), n);
    endtask

    task automatic clear_got();
        got_data.delete();
        got_addr.delete();
    endtask

    task automatic send(input logic [31:0] a);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        next();
        bus.req_valid = 1'b0;
    endtask

    task automatic load_seed(input logic [31:0] s);
        bus.seed_load = 1'b1;
        bus.seed      = s;
        next();
        bus.seed_load = 1'b0;
    endtask

    initial begin
        int acc;
        cyc = 0;
        reset_n        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b0;
        bus.kill       = 1'b0;
        bus.seed_load  = 1'b0;
        bus.seed       = '0;
        repeat (3) next();
        check("rst_lit_ready", bus.req_ready, 0);
        reset_n = 1'b1;
        next();
        @(negedge clk);
        check("ready_after_reset", bus.req_ready, 1);
        next();

        // Warmup NOPs then first LFSR instruction
        bus.resp_ready = 1'b1;
        clear_got();
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req_addr = 32'h100 + 32'(4 * i);
            next();
        end
        bus.req_valid = 1'b0;
        wait_got(3, 10);
        if (got_data.size() >= 3) begin
            check("warm0", got_data[0], 32'h00000013);
            check("warm1", got_data[1], 32'h00000013);
            check("first_op", got_data[2], 32'h00000193);
            check("first_addr", got_addr[2], 32'h108);
        end

        // funct3 masking
        clear_got();
        load_seed(32'hFFFFDFFF);
        send(32'h200);
        wait_got(1, 10);
        if (got_data.size() >= 1) check("srai_mask", got_data[0], 32'h41FFDF93);
        clear_got();
        load_seed(32'hFFFF9FFF);
        send(32'h204);
        wait_got(1, 10);
        if (got_data.size() >= 1) check("slli_mask", got_data[0], 32'h01FF9F93);

        // Backpressure
        clear_got();
        bus.resp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 32'h300 + 32'(4 * acc);
            @(negedge clk);
            if (bus.req_ready) acc++;
            next();
        end
        bus.req_valid = 1'b0;
        check("bp_accepts", acc, 4);
        @(negedge clk);
        check("bp_full_ready", bus.req_ready, 0);
        next();
        repeat (2) next();
        bus.resp_ready = 1'b1;
        wait_got(4, 12);
        for (int i = 0; i < 4 && i < got_addr.size(); i++)
            check("bp_addr", got_addr[i], 32'h300 + 32'(4 * i));

        // kill with a request presented in the same cycle
        clear_got();
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h400 + 32'(4 * i));
        bus.kill      = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h4F0;
        next();
        bus.kill      = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("kill_valid", bus.resp_valid, 0);
        bus.resp_ready = 1'b1;
        repeat (5) next();
        check("kill_no_stale", got_data.size(), 0);
        send(32'h500);
        wait_got(1, 10);
        if (got_addr.size() >= 1) check("post_kill_addr", got_addr[0], 32'h500);

        // Async reset with two outstanding requests
        clear_got();
        bus.resp_ready = 1'b0;
        send(32'h600);
        send(32'h604);
        @(negedge clk);
        check("pre_rst_valid", bus.resp_valid, 1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", bus.resp_valid, 0);
        repeat (2) next();
        reset_n = 1'b1;
        next();
        bus.resp_ready = 1'b1;
        send(32'h700);
        send(32'h704);
        wait_got(2, 10);
        if (got_data.size() >= 2) begin
            check("rewarm0", got_data[0], 32'h00000013);
            check("rewarm1", got_data[1], 32'h00000013);
            check("rewarm_addr", got_addr[0], 32'h700);
        end
        repeat (3) next();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
